irq_request: RTL

- SoC-side interrupt request controller: the peripheral end of the CPU interrupt interface.
- Owns the IF register (0xFF0F). Edge-detects peripheral events (VBlank, STAT, Timer, Serial, Joypad) and drives per-source request levels on CPU_IRQ_TRIG.
- Clears flags on the CPU's one-hot CPU_IRQ_ACK and serves CPU reads/writes of 0xFF0F.
- Sits outside the SM83 core, alongside the peripheral blocks.

---
 rtl/sm83_irq_pkg.sv | 26 ++
 rtl/irq_edge_det.sv | 36 +++
 rtl/irq_request.sv | 73 +++++++
 3 files changed

// File: rtl/sm83_irq_pkg.sv
// Shared interrupt constants for the SM83 interrupt interface: source indices,
// register addresses and vector layout.
package sm83_irq_pkg;

  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  localparam int unsigned IRQ_NSRC = 5;

  localparam logic [15:0] IRQ_IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IRQ_IE_ADDR = 16'hFFFF;

  localparam logic [7:0]  IRQ_VEC_BASE   = 8'h40;
  localparam int unsigned IRQ_VEC_STRIDE = 8;

  typedef logic [IRQ_NSRC-1:0] irq_vec_t;

  // Restart vector for a given source index.
  function automatic logic [7:0] irq_vector(input logic [2:0] src);
    return IRQ_VEC_BASE + 8'(src) * 8'(IRQ_VEC_STRIDE);
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Per-bit rising-edge detector with an optional 2-flop synchronizer per bit.
// All history flops reset to 1 so a level held across reset release is not an edge.
module irq_edge_det #(
  parameter int unsigned   W    = 5,
  parameter logic [W-1:0]  SYNC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] s;
  logic [W-1:0] q;

  for (genvar i = 0; i < W; i++) begin : g_bit
    if (SYNC[i]) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], d[i]};
      end
      assign s[i] = sync_q[1];
    end else begin : g_direct
      assign s[i] = d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '1;
    else        q <= s;
  end

  assign rise_c = s & ~q;

endmodule

// File: rtl/irq_request.sv
// IF register (0xFF0F) and CPU interrupt request levels for the SM83.
// Optional IRQ_REQUEST_OVERRUN_EN adds sticky per-source OVERRUN flags.
module irq_request
  import sm83_irq_pkg::*;
#(
  parameter int unsigned      NSRC    = IRQ_NSRC,
  parameter logic [NSRC-1:0]  EV_SYNC = NSRC'(5'b10000),
  parameter logic [15:0]      IF_ADDR = IRQ_IF_ADDR
) (
  input  logic            CLK,
  input  logic            nRES,
  input  logic [15:0]     A,
  input  logic [7:0]      D_IN,
  output logic [7:0]      D_OUT,
  output logic            D_OE,
  input  logic            RD,
  input  logic            WR,
  input  logic [NSRC-1:0] EV,
  input  logic [7:0]      CPU_IRQ_ACK,
  output logic [7:0]      CPU_IRQ_TRIG
`ifdef IRQ_REQUEST_OVERRUN_EN
  ,output logic [NSRC-1:0] OVERRUN
`endif
);

  localparam int unsigned PAD = 8 - NSRC;

  logic [NSRC-1:0] if_q;
  logic [NSRC-1:0] ev_set;
  logic [NSRC-1:0] ack_clr;
  logic            wr_hit;
  logic            rd_hit;
  logic            unused_bits;

  irq_edge_det #(.W(NSRC), .SYNC(EV_SYNC)) u_ev_det (
    .clk    (CLK),
    .rst_n  (nRES),
    .d      (EV),
    .rise_c (ev_set)
  );

  // Edged ack so a multi-cycle acknowledge clears its flag only once.
  irq_edge_det #(.W(NSRC), .SYNC('0)) u_ack_det (
    .clk    (CLK),
    .rst_n  (nRES),
    .d      (CPU_IRQ_ACK[NSRC-1:0]),
    .rise_c (ack_clr)
  );

  assign wr_hit = WR && (A == IF_ADDR);
  assign rd_hit = RD && (A == IF_ADDR);

  // Event set wins over ack clear, which wins over the CPU write.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) if_q <= '0;
    else       if_q <= ((wr_hit ? D_IN[NSRC-1:0] : if_q) & ~ack_clr) | ev_set;
  end

`ifdef IRQ_REQUEST_OVERRUN_EN
  // Sticky: an edge landed on a request the CPU had not yet taken.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) OVERRUN <= '0;
    else       OVERRUN <= (wr_hit ? '0 : OVERRUN) | (ev_set & if_q & ~ack_clr);
  end
`endif

  assign CPU_IRQ_TRIG = {{PAD{1'b0}}, if_q};
  assign D_OUT        = {{PAD{1'b1}}, if_q};
  assign D_OE         = rd_hit;

  assign unused_bits = &{1'b0, D_IN[7:NSRC], CPU_IRQ_ACK[7:NSRC]};

endmodule
